// File: rtl/uparc_rf_wb_ctrl_pkg.sv
// Shared constants and helpers for the register-file write-back controller.
package uparc_rf_wb_ctrl_pkg;

  localparam int WB_NREQ    = 3;
  localparam int RF_REGNO_W = 5;
  localparam int RF_REG_W   = 32;
  localparam int NGPR       = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

  // One-hot scoreboard mask for a register number; R0 never owns a bit.
  function automatic logic [NGPR-1:0] reg_mask(input logic [RF_REGNO_W-1:0] regno);
    logic [NGPR-1:0] one;
    one = {{(NGPR-1){1'b0}}, 1'b1};
    return (one << regno) & ~one;
  endfunction

endpackage

// File: rtl/uparc_rf_wb_ctrl_if.sv
// Bundle of issue, hazard-query, write-back request and register-file write signals.
interface uparc_rf_wb_ctrl_if
  import uparc_rf_wb_ctrl_pkg::*;
#(
  parameter int NREQ    = WB_NREQ,
  parameter int REGNO_W = RF_REGNO_W,
  parameter int REG_W   = RF_REG_W
);

  logic                    iss_valid;
  logic [REGNO_W-1:0]      iss_rd;
  logic [REGNO_W-1:0]      q_rs;
  logic [REGNO_W-1:0]      q_rt;
  logic                    q_rs_busy;
  logic                    q_rt_busy;
  logic [NREQ-1:0]         wb_req;
  logic [NREQ*REGNO_W-1:0] wb_rd;
  logic [NREQ*REG_W-1:0]   wb_data;
  logic [NREQ-1:0]         wb_gnt;
  logic [REGNO_W-1:0]      rf_rd;
  logic [REG_W-1:0]        rf_rd_data;
  logic [NGPR-1:0]         busy_vec;
  logic                    sb_err;

  modport master (
    output iss_valid, iss_rd, q_rs, q_rt, wb_req, wb_rd, wb_data,
    input  q_rs_busy, q_rt_busy, wb_gnt, rf_rd, rf_rd_data, busy_vec, sb_err
  );

  modport slave (
    input  iss_valid, iss_rd, q_rs, q_rt, wb_req, wb_rd, wb_data,
    output q_rs_busy, q_rt_busy, wb_gnt, rf_rd, rf_rd_data, busy_vec, sb_err
  );

endinterface

// File: rtl/uparc_rf_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module uparc_rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] idx_s;
  logic [PTR_W-1:0] win_s;
  logic             found_s;

  // Scan from the pointer for the first active request.
  always_comb begin
    gnt     = '0;
    win_s   = ptr_r;
    idx_s   = ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = PTR_W'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        win_s      = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Winner becomes lowest priority; pointer holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= (win_s == PTR_W'(NREQ - 1)) ? '0 : win_s + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/uparc_rf_wb_ctrl.sv
// Register-file write-back controller: shares the single write port between
// execute units and tracks pending destination registers for hazard checks.
module uparc_rf_wb_ctrl
  import uparc_rf_wb_ctrl_pkg::*;
#(
  parameter int NREQ    = WB_NREQ,
  parameter int REGNO_W = RF_REGNO_W,
  parameter int REG_W   = RF_REG_W
) (
  input logic               clk,
  input logic               nrst,
  uparc_rf_wb_ctrl_if.slave bus
);

  logic [NREQ-1:0]    gnt_s;
  logic               gnt_any_s;
  logic [REGNO_W-1:0] sel_rd_s;
  logic [REG_W-1:0]   sel_data_s;
  logic [NGPR-1:0]    set_mask_s;
  logic [NGPR-1:0]    clr_mask_s;
  logic [NGPR-1:0]    busy_nxt_s;
  logic               wb_err_s;

  logic [REGNO_W-1:0] rf_rd_r;
  logic [REG_W-1:0]   rf_data_r;
  logic [NGPR-1:0]    busy_r;
  logic               sb_err_r;

  uparc_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk  (clk),
    .nrst (nrst),
    .req  (bus.wb_req),
    .gnt  (gnt_s)
  );

  // One-hot AND-OR mux of the granted requester's payload.
  always_comb begin
    sel_rd_s   = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_rd_s   = sel_rd_s   | ({REGNO_W{gnt_s[i]}} & bus.wb_rd[i*REGNO_W +: REGNO_W]);
      sel_data_s = sel_data_s | ({REG_W{gnt_s[i]}}   & bus.wb_data[i*REG_W +: REG_W]);
    end
  end

  assign gnt_any_s  = |gnt_s;
  // A fresh issue to the register being written now keeps its busy bit.
  assign set_mask_s = bus.iss_valid ? reg_mask(bus.iss_rd) : '0;
  assign clr_mask_s = reg_mask(rf_rd_r);
  assign busy_nxt_s = set_mask_s | (busy_r & ~clr_mask_s);
  assign wb_err_s   = gnt_any_s & (sel_rd_s != '0) & ~busy_r[sel_rd_s];

  // Output stage, scoreboard and sticky error flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rf_rd_r   <= '0;
      rf_data_r <= '0;
      busy_r    <= '0;
      sb_err_r  <= 1'b0;
    end else begin
      busy_r   <= busy_nxt_s;
      sb_err_r <= sb_err_r | wb_err_s;
      if (gnt_any_s) begin
        rf_rd_r   <= sel_rd_s;
        rf_data_r <= sel_data_s;
      end else begin
        rf_rd_r   <= '0;
        rf_data_r <= rf_data_r;
      end
    end
  end

  // The register being written this cycle is covered by the file's read bypass.
  assign bus.q_rs_busy  = busy_r[bus.q_rs] & (rf_rd_r != bus.q_rs);
  assign bus.q_rt_busy  = busy_r[bus.q_rt] & (rf_rd_r != bus.q_rt);
  assign bus.wb_gnt     = gnt_s;
  assign bus.rf_rd      = rf_rd_r;
  assign bus.rf_rd_data = rf_data_r;
  assign bus.busy_vec   = busy_r;
  assign bus.sb_err     = sb_err_r;

endmodule
